// File: rtl/operand_gather5x12_pkg.sv
// Shared constants and types for the five-operand gather stage that feeds the 12-bit Dadda adder.
// The hold bank's a..e slots are summed downstream in SUM_W bits.
package operand_gather5x12_pkg;

  localparam int WIDTH   = 12;
  localparam int NUM_OPS = 5;
  localparam int CNT_W   = 3;
  localparam int SUM_W   = WIDTH + 3;

  typedef logic [NUM_OPS-1:0][WIDTH-1:0] op_array_t;

  typedef struct packed {
    op_array_t        ops;
    logic [CNT_W-1:0] count;
  } op_group_t;

  // 5 * 4095 = 20475 fits in SUM_W bits, so this sum never wraps.
  function automatic logic [SUM_W-1:0] group_sum(input op_array_t ops);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_OPS; i++) s = s + SUM_W'(ops[i]);
    return s;
  endfunction

endpackage

// File: rtl/operand_gather5x12_bank.sv
// NUM_OPS x WIDTH register bank with indexed write, bulk load and synchronous clear.
// Clear wins over load, and load wins over an indexed write.
module operand_bank
  import operand_gather5x12_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             load_en,
  input  op_array_t        load_data,
  output op_array_t        data
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
    end else if (load_en) begin
      data <= load_data;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (wr_idx == CNT_W'(i)) data[i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/operand_gather5x12.sv
// Packs a serial operand stream into zero-padded groups of five, double-buffered into a
// fill bank and a hold bank that drives a..e to the adder.
module operand_gather5x12
  import operand_gather5x12_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  // Handshake: a word moves when in_valid & in_ready, a group moves when out_valid & out_ready.
  // in_ready comes only from registered state; a..e/out_count are held while out_valid & !out_ready.

  logic [CNT_W-1:0] fill_cnt;
  logic             fill_done;
  op_array_t        fill_data;
  op_array_t        hold_data;
  op_group_t        next_grp;

  logic accept, xfer, hold_free, complete, move_now, move_pend, move;

  assign in_ready  = !fill_done;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign hold_free = !out_valid || xfer;
  assign complete  = accept && (in_last || (fill_cnt == CNT_W'(NUM_OPS - 1)));
  assign move_now  = complete && hold_free;
  assign move_pend = fill_done && xfer;
  assign move      = move_now || move_pend;

  // The group handed to hold includes the word being accepted on this same edge.
  always_comb begin
    next_grp.ops   = fill_data;
    next_grp.count = fill_cnt + CNT_W'(1);
    if (accept) next_grp.ops[fill_cnt] = in_data;
  end

  operand_bank u_fill (
    .clk       (clk),
    .rst       (rst),
    .clr       (move),
    .wr_en     (accept && !move_now),
    .wr_idx    (fill_cnt),
    .wr_data   (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .data      (fill_data)
  );

  operand_bank u_hold (
    .clk       (clk),
    .rst       (rst),
    .clr       (xfer && !move),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .load_en   (move),
    .load_data (next_grp.ops),
    .data      (hold_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= '0;
      fill_done <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else if (move) begin
      out_valid <= 1'b1;
      out_count <= next_grp.count;
      fill_cnt  <= '0;
      fill_done <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
        out_count <= '0;
      end
      // A group completed against a busy hold bank parks with fill_cnt at its last slot.
      if (complete)    fill_done <= 1'b1;
      else if (accept) fill_cnt  <= fill_cnt + CNT_W'(1);
    end
  end

  assign a = hold_data[0];
  assign b = hold_data[1];
  assign c = hold_data[2];
  assign d = hold_data[3];
  assign e = hold_data[4];

endmodule

// File: tb/tb_operand_gather5x12.sv
// Randomised and directed bench for operand_gather5x12 against a queue-based grouping model.
module tb_operand_gather5x12;

  localparam int W  = 12;
  localparam int GW = 3 + 5 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid, in_last, in_ready;
  logic [W-1:0]  a, b, c, d, e;
  logic          out_valid, out_ready;
  logic [2:0]    out_count;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0]  cur_q[$];
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] got_q[$];

  operand_gather5x12 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Reference: collect accepted words; close a group at five words or on last, pad with zeros.
  function automatic void model_accept(input logic [W-1:0] wd, input logic wl);
    logic [GW-1:0] g;
    cur_q.push_back(wd);
    if (cur_q.size() == 5 || wl) begin
      g = '0;
      for (int i = 0; i < cur_q.size(); i++) g[i*W +: W] = cur_q[i];
      g[GW-1 -: 3] = 3'(cur_q.size());
      exp_q.push_back(g);
      cur_q.delete();
    end
  endfunction

  function automatic int gsum(input logic [GW-1:0] g);
    int s = 0;
    for (int i = 0; i < 5; i++) s += int'(g[i*W +: W]);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur_q.delete(); exp_q.delete(); got_q.delete();
  endtask

  // One clock: drive at negedge, record accepts into the model and transfers into got_q.
  task automatic step(input logic v, input logic [W-1:0] wd, input logic wl, input logic r,
                      output logic acc);
    @(negedge clk);
    in_valid = v; in_data = wd; in_last = wl; out_ready = r;
    acc = in_valid && in_ready;
    if (acc) model_accept(wd, wl);
    if (out_valid && out_ready) got_q.push_back({out_count, e, d, c, b, a});
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] wd, input logic wl, input logic r);
    logic acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) step(1'b1, wd, wl, r, acc);
    if (!acc) begin
      compared++; mismatched++;
      $display("FAIL send_timeout got=in_ready stuck low exp=word %h accepted", wd);
    end
  endtask

  task automatic drain();
    logic acc;
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({out_valid, out_count, a, b, c, d, e} !== '0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state got=v%b n%0d %h %h %h %h %h rdy%b exp=all zero rdy1",
               out_valid, out_count, a, b, c, d, e, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [GW-1:0] g;
    do_reset();
    for (int i = 1; i <= 5; i++) send_word(W'(i), 1'b0, 1'b1);
    compared++;
    if (out_valid !== 1'b1 || {a, b, c, d, e} !== {12'd1, 12'd2, 12'd3, 12'd4, 12'd5}) begin
      mismatched++;
      $display("FAIL basic_latency got=v%b %h %h %h %h %h exp=v1 1 2 3 4 5", out_valid, a, b, c, d, e);
    end
    drain();
    compared++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      mismatched++;
      $display("FAIL basic_groups got=%0d exp=1 (model %0d)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front() || gsum(g) != 15) begin
        mismatched++;
        $display("FAIL basic_group got=%h sum=%0d exp=1..5 sum=15", g, gsum(g));
      end
    end
  endtask

  task automatic test_max();
    logic [GW-1:0] g;
    do_reset();
    repeat (5) send_word(12'hFFF, 1'b0, 1'b1);
    drain();
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL max_groups got=%0d exp=1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front() || gsum(g) != 20475) begin
        mismatched++;
        $display("FAIL max_group got=%h sum=%0d exp=all FFF sum=20475", g, gsum(g));
      end
    end
  endtask

  task automatic test_last();
    logic [GW-1:0] g;
    do_reset();
    send_word(12'd7, 1'b0, 1'b1);
    send_word(12'd9, 1'b1, 1'b1);
    compared++;
    if ({a, b, c, d, e} !== {12'd7, 12'd9, 36'd0} || out_count !== 3'd2) begin
      mismatched++;
      $display("FAIL last_pad got=%h %h %h %h %h n%0d exp=7 9 0 0 0 n2", a, b, c, d, e, out_count);
    end
    for (int i = 1; i <= 5; i++) send_word(W'(i), 1'b0, 1'b1);
    drain();
    compared++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      mismatched++;
      $display("FAIL last_groups got=%0d exp=2", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front()) begin
        mismatched++;
        $display("FAIL last_group got=%h", g);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [GW-1:0] g;
    logic [W-1:0]  w2;
    logic          acc;
    do_reset();
    for (int i = 1; i <= 5; i++) send_word(W'(i), 1'b0, 1'b0);
    w2 = W'($urandom_range(0, 4095));
    send_word(w2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_word(W'($urandom_range(0, 4095)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'($urandom_range(0, 4095)), 1'b0, 1'b0, acc);
      compared++;
      if (acc !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {a, b, c, d, e} !== {12'd1, 12'd2, 12'd3, 12'd4, 12'd5}) begin
        mismatched++;
        $display("FAIL bp_hold got=acc%b rdy%b v%b %h %h %h %h %h exp=acc0 rdy0 v1 1 2 3 4 5",
                 acc, in_ready, out_valid, a, b, c, d, e);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1, acc);
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || a !== w2) begin
      mismatched++;
      $display("FAIL bp_release got=v%b rdy%b a=%h exp=v1 rdy1 a=%h", out_valid, in_ready, a, w2);
    end
    for (int i = 0; i < 5; i++) send_word(W'($urandom_range(0, 4095)), 1'b0, 1'b0);
    drain();
    compared++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      mismatched++;
      $display("FAIL bp_groups got=%0d exp=3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front()) begin
        mismatched++;
        $display("FAIL bp_group got=%h", g);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [GW-1:0] g;
    logic          acc;
    int            bubbles = 0;
    int            k = 0;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b1, acc);
      if (!acc) bubbles++;
    end
    compared++;
    if (bubbles != 0) begin
      mismatched++;
      $display("FAIL b2b_bubbles got=%0d exp=0", bubbles);
    end
    drain();
    compared++;
    if (got_q.size() != 4) begin
      mismatched++;
      $display("FAIL b2b_groups got=%0d exp=4", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front() || gsum(g) != 15 + 25 * k) begin
        mismatched++;
        $display("FAIL b2b_group got=%h sum=%0d exp sum=%0d", g, gsum(g), 15 + 25 * k);
      end
      k++;
    end
  endtask

  task automatic test_random();
    logic [GW-1:0] g;
    logic          acc;
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, W'($urandom_range(0, 4095)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, acc);
    drain();
    compared++;
    if (got_q.size() != exp_q.size() || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rand_groups got=%0d exp=%0d v=%b", got_q.size(), exp_q.size(), out_valid);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front()) begin
        mismatched++;
        $display("FAIL rand_group got=%h", g);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [GW-1:0] g;
    do_reset();
    send_word(12'd10, 1'b0, 1'b0);
    send_word(12'd11, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) send_word(W'(i), 1'b0, 1'b0);
    do_reset();
    compared++;
    if ({out_valid, out_count, a, b, c, d, e} !== '0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_state got=v%b n%0d %h %h %h %h %h exp=all zero",
               out_valid, out_count, a, b, c, d, e);
    end
    for (int i = 4; i <= 8; i++) send_word(W'(i), 1'b0, 1'b1);
    drain();
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL midreset_groups got=%0d exp=1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q.pop_front() || g[W-1:0] !== 12'd4) begin
        mismatched++;
        $display("FAIL midreset_group got=%h exp=4..8", g);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_last();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_gather5x12.md
Name: operand_gather5x12

Overview:
- Upstream feeder for the five-operand, 12-bit Dadda adder stage (15-bit sum).
- Accepts a serial stream of 12-bit operands, one per handshake, and packs them into groups of five.
- A group closes at five operands, or early on in_last, which zero-pads the remaining slots.
- Double-buffered: a fill bank collects the next group while a hold bank drives a..e to the adder with a valid/ready handshake.

Parameters:
- WIDTH, 12, operand width in bits.
- NUM_OPS, 5, operands per group; fixed to match the adder.
- CNT_W, 3, width of the slot counter and out_count.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  operand word.
- in_valid  in  1  in_data valid.
- in_last  in  1  accepted word closes the current group; qualified by in_valid.
- in_ready  out  1  block can accept a word this cycle.
- a, b, c, d, e  out  WIDTH each  hold-bank slots 0..4, wired to the adder operands.
- out_valid  out  1  a..e hold a complete group.
- out_ready  in  1  consumer (adder/result register) takes the group this cycle.
- out_count  out  CNT_W  number of real operands in the group, 1..5; padded slots read 0.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All fill and hold slots go to 0; fill_cnt=0; fill_done=0.
  - out_valid=0; out_count=0; a..e=0; in_ready=1 from the first cycle after reset.
- Reset mid-group discards any partial group and any held group; nothing is emitted.
- Handshake rules:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !fill_done; it is purely registered-state based and never depends combinationally on in_valid.
  - out_valid, a..e and out_count are registered. They stay stable while out_valid=1 and out_ready=0.
- Fill side, on an accept:
  - Write in_data to fill slot fill_cnt.
  - If fill_cnt==NUM_OPS-1 or in_last=1, the group is complete with count fill_cnt+1; otherwise fill_cnt increments.
- Completion, same edge as the completing accept:
  - If the hold bank is free (out_valid=0, or a transfer occurs this cycle), the completed group, including the word just written, moves straight into hold.
  - out_valid=1 from the next cycle, out_count=group size. The fill bank clears to 0 and fill_cnt=0.
  - If the hold bank is busy, set fill_done=1, which drops in_ready.
- Pending transfer: when fill_done=1 and the hold bank frees (transfer occurs), move fill to hold on that edge. Clear fill, fill_done=0, so in_ready returns the next cycle.
- Hold side, transfer with no replacement: out_valid=0; a..e and out_count clear to 0.
- Latency: completing word accepted at edge N gives out_valid high in cycle N+1 when hold is free.
- Throughput: with out_ready held at 1 there are no input bubbles; one group every NUM_OPS accepts.
- Padding: unused slots are 0 because the fill bank is cleared on every move. A 1-operand group gives a=x, b..e=0.
- Widths: 5*4095=20475 < 2^15, so the downstream sum never overflows; this block does no arithmetic.
- Simultaneous events:
  - Completing accept plus out transfer in the same cycle gives back-to-back groups with out_valid staying 1.
  - in_last on the fifth word is equivalent to a normal full group.
- in_valid=0 leaves all state unchanged. in_data and in_last are don't-care when not accepted.

Decomposition:
- Shared package holds: WIDTH, NUM_OPS, CNT_W constants; the 15-bit sum width (WIDTH+3) for the adder chain; and an operand-group typedef (NUM_OPS x WIDTH array plus count).
- One sub-module is natural: operand_bank, a NUM_OPS x WIDTH register array with indexed write, bulk load, and synchronous clear.
- It is instantiated twice, once as the fill bank and once as the hold bank.

Test Plan:
- Reset then stream 1,2,3,4,5 with out_ready=1 -> out_valid in the cycle after the 5th accept; a..e=1,2,3,4,5; out_count=5; adder sum 15.
- Stream 0xFFF x5 -> a..e=0xFFF; downstream sum 20475 (15'h4FFB), no overflow.
- Words 7, 9 with in_last on 9 -> a=7, b=9, c=d=e=0; out_count=2; next group starts at slot a.
- out_ready=0 while 10 further words arrive:
  - The 1st group is held stable.
  - The 2nd group fills and fill_done=1, so in_ready=0.
  - Raise out_ready for one cycle -> the 2nd group appears next cycle and in_ready returns to 1.
  - The extra words are never lost or overwritten.
- Continuous in_valid=1 with out_ready=1 for 20 words 1..20 -> 4 groups back-to-back, in_ready never drops, sums 15, 40, 65, 90.
- Assert rst after 3 words of a group -> out_valid=0, a..e=0; subsequent words 4,5,6,7,8 form a clean group a=4..e=8.
